alu8_regfile_core: RTL and testbench

- 8-bit registered ALU with 16 opcodes: arithmetic, logic, compare, shift/rotate and Gray conversion.
- Operands come from the accumulator (accum) and the B register (b_reg).
- Result and flags (carry, zero, done) are registered; a combinational operand mux output (mux_o) is exposed for the datapath.
- Sits between the register file and the writeback path of the small CPU datapath.

---
 rtl/alu8_pkg.sv | 41 ++++
 rtl/alu8_comb.sv | 97 +++++++++
 rtl/alu8_regfile_core.sv | 77 +++++++
 tb/tb_alu8_regfile_core.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu8_pkg
// Description : Shared definitions for the 8-bit registered ALU: opcode
//               encoding, compare result codes and shift-mode bit positions.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package alu8_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_MOD  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_XOR  = 4'b0111,
      OP_NOT  = 4'b1000,
      OP_NAND = 4'b1001,
      OP_NOR  = 4'b1010,
      OP_XNOR = 4'b1011,
      OP_CMP  = 4'b1100,
      OP_SHF  = 4'b1101,
      OP_GRAY = 4'b1110,
      OP_CLR  = 4'b1111
   } op_e;

   localparam logic [7:0] CMP_GT = 8'h01;
   localparam logic [7:0] CMP_LT = 8'h02;
   localparam logic [7:0] CMP_EQ = 8'h04;

   // Mode bits inside operand B for the shift opcode; lower index wins.
   localparam int SHM_SHL = 4;
   localparam int SHM_SHR = 5;
   localparam int SHM_ROL = 6;
   localparam int SHM_ROR = 7;

endpackage : alu8_pkg
`default_nettype wire

// File: rtl/alu8_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu8_comb
// Description : Combinational ALU core. Produces the next result and carry
//               from operands A/B, the opcode and the operand-mux value.
// Ports       : i_a, i_b    - operands (B also carries shift control)
//               i_op        - opcode
//               i_mux       - operand mux value (Gray conversion source)
//               o_y, o_carry- next result and carry
// Revision    : 1.0 - initial release
// ============================================================================
module alu8_comb
   import alu8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  op_e              i_op,
   input  logic [WIDTH-1:0] i_mux,
   output logic [WIDTH-1:0] o_y,
   output logic             o_carry
);

   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;
   logic [2*WIDTH-1:0]   w_prod;
   logic [2:0]           w_n;
   logic [WIDTH:0]       w_shl;   // bit WIDTH holds the last bit shifted out
   logic [WIDTH:0]       w_shr;   // bit 0 holds the last bit shifted out
   logic [WIDTH-1:0]     w_rol;
   logic [WIDTH-1:0]     w_ror;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};   // MSB set means borrow
   assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
   assign w_n    = i_b[2:0];
   assign w_shl  = {1'b0, i_a} << w_n;
   assign w_shr  = {i_a, 1'b0} >> w_n;
   // Rotates only used for n>=1, so the complementary shift stays < WIDTH.
   assign w_rol  = (i_a << w_n) | (i_a >> (WIDTH - int'(w_n)));
   assign w_ror  = (i_a >> w_n) | (i_a << (WIDTH - int'(w_n)));

   always_comb begin
      o_y     = '0;
      o_carry = 1'b0;
      case (i_op)
         OP_ADD:  begin o_y = w_sum[WIDTH-1:0];  o_carry = w_sum[WIDTH];  end
         OP_SUB:  begin o_y = w_diff[WIDTH-1:0]; o_carry = w_diff[WIDTH]; end
         OP_MUL:  begin
            o_y     = w_prod[WIDTH-1:0];
            o_carry = |w_prod[2*WIDTH-1:WIDTH];
         end
         OP_DIV:  begin
            if (i_b == '0) begin o_y = '1; o_carry = 1'b1; end
            else                 o_y = i_a / i_b;
         end
         OP_MOD:  begin
            if (i_b == '0) begin o_y = i_a; o_carry = 1'b1; end
            else                 o_y = i_a % i_b;
         end
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_XOR:  o_y = i_a ^ i_b;
         OP_NOT:  o_y = ~i_a;
         OP_NAND: o_y = ~(i_a & i_b);
         OP_NOR:  o_y = ~(i_a | i_b);
         OP_XNOR: o_y = ~(i_a ^ i_b);
         OP_CMP:  begin
            if (i_a > i_b)      o_y = CMP_GT;
            else if (i_a < i_b) o_y = CMP_LT;
            else                o_y = CMP_EQ;
         end
         OP_SHF:  begin
            o_y = i_a;
            if (w_n != 3'd0) begin
               if (i_b[SHM_SHL]) begin
                  o_y     = w_shl[WIDTH-1:0];
                  o_carry = w_shl[WIDTH];
               end else if (i_b[SHM_SHR]) begin
                  o_y     = w_shr[WIDTH:1];
                  o_carry = w_shr[0];
               end else if (i_b[SHM_ROL]) begin
                  o_y = w_rol;
               end else if (i_b[SHM_ROR]) begin
                  o_y = w_ror;
               end
            end
         end
         OP_GRAY: o_y = i_mux ^ (i_mux >> 1);
         OP_CLR:  o_y = '0;
         default: o_y = '0;
      endcase
   end

endmodule : alu8_comb
`default_nettype wire

// File: rtl/alu8_regfile_core.sv
`default_nettype none
// ============================================================================
// Module      : alu8_regfile_core
// Description : 8-bit registered ALU. Registers result, carry, zero and done
//               each clock; exposes the combinational operand mux.
// Ports       : clk, rst      - clock, async active-high reset
//               accum, b_reg  - operands A and B
//               a_in          - opcode
//               in_it         - synchronous clear
//               mux_s         - operand select (0 accum, 1 b_reg)
//               y_out, carry, zero, done - registered result and flags
//               mux_o         - combinational operand mux
// Revision    : 1.0 - initial release
// ============================================================================
module alu8_regfile_core
   import alu8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] accum,
   input  logic [WIDTH-1:0] b_reg,
   input  logic [3:0]       a_in,
   input  logic             in_it,
   input  logic             mux_s,
   output logic [WIDTH-1:0] y_out,
   output logic             carry,
   output logic             zero,
   output logic             done,
   output logic [WIDTH-1:0] mux_o
);

   logic [WIDTH-1:0] w_y;
   logic             w_carry;
   logic [WIDTH-1:0] r_y;
   logic             r_carry;
   logic             r_zero;
   logic             r_done;

   assign mux_o = mux_s ? b_reg : accum;

   alu8_comb #(.WIDTH(WIDTH)) u_comb (
      .i_a     (accum),
      .i_b     (b_reg),
      .i_op    (op_e'(a_in)),
      .i_mux   (mux_o),
      .o_y     (w_y),
      .o_carry (w_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y     <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b1;
         r_done  <= 1'b0;
      end else if (in_it) begin
         r_y     <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_y     <= w_y;
         r_carry <= w_carry;
         r_zero  <= (w_y == '0);
         r_done  <= 1'b1;
      end
   end

   assign y_out = r_y;
   assign carry = r_carry;
   assign zero  = r_zero;
   assign done  = r_done;

endmodule : alu8_regfile_core
`default_nettype wire

// File: tb/tb_alu8_regfile_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu8_regfile_core
// Description : Directed self-checking bench for alu8_regfile_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu8_regfile_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] accum;
   logic [7:0] b_reg;
   logic [3:0] a_in;
   logic       in_it;
   logic       mux_s;
   logic [7:0] y_out;
   logic       carry;
   logic       zero;
   logic       done;
   logic [7:0] mux_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu8_regfile_core #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .accum (accum),
      .b_reg (b_reg),
      .a_in  (a_in),
      .in_it (in_it),
      .mux_s (mux_s),
      .y_out (y_out),
      .carry (carry),
      .zero  (zero),
      .done  (done),
      .mux_o (mux_o)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp_v);
      end
   endtask

   // Drive one operation on the falling edge, sample 1 ns after the rising edge.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ms, input logic [7:0] ey,
                         input logic ec, input logic ez);
      @(negedge clk);
      a_in = op; accum = a; b_reg = b; mux_s = ms; in_it = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".y"},    y_out,       ey);
      check({tag, ".c"},    {7'd0, carry}, {7'd0, ec});
      check({tag, ".z"},    {7'd0, zero},  {7'd0, ez});
      check({tag, ".done"}, {7'd0, done},  8'd1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ".y"},    y_out,         8'h00);
      check({tag, ".c"},    {7'd0, carry}, 8'd0);
      check({tag, ".z"},    {7'd0, zero},  8'd1);
      check({tag, ".done"}, {7'd0, done},  8'd0);
   endtask

   initial begin
      rst = 1'b1; in_it = 1'b0; a_in = 4'h0; accum = 8'h00; b_reg = 8'h5A; mux_s = 1'b1;
      #12;
      check_cleared("reset");
      check("reset.mux_o", mux_o, 8'h5A);

      @(negedge clk);
      rst = 1'b0; in_it = 1'b1; a_in = 4'b0000; accum = 8'hFF; b_reg = 8'hFF;
      @(posedge clk); #1;
      check_cleared("init");

      run_op("add_ff_ff", 4'b0000, 8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0);
      run_op("sub_155_25", 4'b0001, 8'd155, 8'd25, 1'b0, 8'd130, 1'b0, 1'b0);
      run_op("sub_5_25",   4'b0001, 8'd5,   8'd25, 1'b0, 8'd236, 1'b1, 1'b0);
      run_op("add_1_255",  4'b0000, 8'd1,   8'd255, 1'b0, 8'd0,  1'b1, 1'b1);
      run_op("mul_50_5",   4'b0010, 8'd50,  8'd5,  1'b0, 8'd250, 1'b0, 1'b0);
      run_op("mul_25_25",  4'b0010, 8'd25,  8'd25, 1'b0, 8'd113, 1'b1, 1'b0);
      run_op("div_50_5",   4'b0011, 8'd50,  8'd5,  1'b0, 8'd10,  1'b0, 1'b0);
      run_op("mod_25_5",   4'b0100, 8'd25,  8'd5,  1'b0, 8'd0,   1'b0, 1'b1);
      run_op("div_5_0",    4'b0011, 8'd5,   8'd0,  1'b0, 8'hFF,  1'b1, 1'b0);
      run_op("mod_37_0",   4'b0100, 8'd37,  8'd0,  1'b0, 8'd37,  1'b1, 1'b0);
      run_op("and",        4'b0101, 8'hF0,  8'h3C, 1'b0, 8'h30,  1'b0, 1'b0);
      run_op("or",         4'b0110, 8'hF0,  8'h3C, 1'b0, 8'hFC,  1'b0, 1'b0);
      run_op("xor",        4'b0111, 8'hF0,  8'h3C, 1'b0, 8'hCC,  1'b0, 1'b0);
      run_op("not",        4'b1000, 8'h0F,  8'h3C, 1'b0, 8'hF0,  1'b0, 1'b0);
      run_op("nand",       4'b1001, 8'hF0,  8'h3C, 1'b0, 8'hCF,  1'b0, 1'b0);
      run_op("nor",        4'b1010, 8'hF0,  8'h3C, 1'b0, 8'h03,  1'b0, 1'b0);
      run_op("xnor",       4'b1011, 8'hF0,  8'h3C, 1'b0, 8'h33,  1'b0, 1'b0);
      run_op("cmp_gt",     4'b1100, 8'd10,  8'd5,  1'b0, 8'h01,  1'b0, 1'b0);
      run_op("cmp_lt",     4'b1100, 8'd10,  8'd55, 1'b0, 8'h02,  1'b0, 1'b0);
      run_op("cmp_eq",     4'b1100, 8'd10,  8'd10, 1'b0, 8'h04,  1'b0, 1'b0);
      run_op("shl1",       4'b1101, 8'h0A,  8'h11, 1'b0, 8'd20,  1'b0, 1'b0);
      run_op("shr1",       4'b1101, 8'h0A,  8'h21, 1'b0, 8'd5,   1'b0, 1'b0);
      run_op("rol1",       4'b1101, 8'h0A,  8'h41, 1'b0, 8'd20,  1'b0, 1'b0);
      run_op("ror1",       4'b1101, 8'h0A,  8'h81, 1'b0, 8'd5,   1'b0, 1'b0);
      run_op("shl1_c",     4'b1101, 8'h81,  8'h11, 1'b0, 8'h02,  1'b1, 1'b0);
      run_op("shl3_c",     4'b1101, 8'hA1,  8'h13, 1'b0, 8'h08,  1'b1, 1'b0);
      run_op("shr3_c",     4'b1101, 8'h0E,  8'h23, 1'b0, 8'h01,  1'b1, 1'b0);
      run_op("ror3",       4'b1101, 8'h0A,  8'h83, 1'b0, 8'h41,  1'b0, 1'b0);
      run_op("shf_prio",   4'b1101, 8'h0A,  8'h31, 1'b0, 8'd20,  1'b0, 1'b0);
      run_op("shf_nomode", 4'b1101, 8'h0A,  8'h01, 1'b0, 8'h0A,  1'b0, 1'b0);
      run_op("shf_n0",     4'b1101, 8'h0A,  8'h10, 1'b0, 8'h0A,  1'b0, 1'b0);

      @(negedge clk);
      mux_s = 1'b0; accum = 8'hA1; #1;
      check("gray_a.mux_o", mux_o, 8'hA1);
      run_op("gray_a",     4'b1110, 8'hA1,  8'h44, 1'b0, 8'hF1,  1'b0, 1'b0);
      run_op("gray_b",     4'b1110, 8'hA1,  8'h44, 1'b1, 8'h66,  1'b0, 1'b0);
      run_op("clear",      4'b1111, 8'h5A,  8'h33, 1'b0, 8'h00,  1'b0, 1'b1);

      // Synchronous clear must override a live opcode.
      run_op("pre_init",   4'b0000, 8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0);
      @(negedge clk);
      in_it = 1'b1;
      @(posedge clk); #1;
      check_cleared("init_override");

      // Asynchronous reset between clock edges.
      run_op("pre_rst",    4'b0000, 8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_cleared("async_rst");
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst",   4'b0001, 8'd5,   8'd25, 1'b0, 8'd236, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_alu8_regfile_core
`default_nettype wire
